alu_operand_sweeper: RTL and testbench

Synthesisable, parametrised stimulus generator that sweeps every ALU operand combination for one ALU operation category and presents each vector over a valid/ready handshake. It is the next generation of the bench-side operand incrementer: width, b-sweep depth and category mode are parameters or inputs. It also adds start/abort control, back-pressure, last/done signalling and a vector index. It sits between a bench or self-test controller and the alu block's a_in_lo/a_in_hi/b_in/carry inputs.

---
 rtl/pkg_alu.sv | 9 +
 rtl/pkg_sweep.sv | 19 +
 rtl/alu_sweep_unpack.sv | 53 +++++
 rtl/alu_operand_sweeper.sv | 102 ++++++++++
 tb/tb_alu_operand_sweeper.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/pkg_alu.sv
// ALU operand category shared by the ALU and its stimulus generators.
package pkg_alu;
  typedef enum logic [1:0] {
    alu_op_cat_8_no_ci,
    alu_op_cat_8_ci,
    alu_op_cat_16_no_ci,
    alu_op_cat_16_ci
  } alu_oper_cat;
endpackage

// File: rtl/pkg_sweep.sv
// Sweep FSM states and the per-category active counter width.
package pkg_sweep;
  import pkg_alu::*;

  typedef enum logic [1:0] {
    SWEEP_IDLE,
    SWEEP_RUN,
    SWEEP_DONE
  } sweep_state;

  function automatic int field_width(alu_oper_cat mode, int w, int bs);
    case (mode)
      alu_op_cat_8_no_ci:  return w + bs;
      alu_op_cat_8_ci:     return w + 1 + bs;
      alu_op_cat_16_no_ci: return 2 * w + bs;
      default:             return 2 * w + 1;
    endcase
  endfunction
endpackage

// File: rtl/alu_sweep_unpack.sv
// Splits the sweep counter into ALU operand fields for the selected category.
module alu_sweep_unpack
  import pkg_alu::*;
  import pkg_sweep::*;
#(
  parameter int INOUT_WIDTH  = 8,
  parameter int B_SWEEP_BITS = 8,
  parameter int CNT_WIDTH    = 2 * INOUT_WIDTH + B_SWEEP_BITS + 1
) (
  input  logic [CNT_WIDTH-1:0]   cnt,
  input  alu_oper_cat            mode,
  output logic [INOUT_WIDTH-1:0] a_lo,
  output logic [INOUT_WIDTH-1:0] a_hi,
  output logic [INOUT_WIDTH-1:0] b,
  output logic                   carry_in,
  output logic                   last
);
  localparam int W  = INOUT_WIDTH;
  localparam int BS = B_SWEEP_BITS;

  logic [CNT_WIDTH-1:0] ones;

  always_comb begin
    a_lo     = '0;
    a_hi     = '0;
    b        = '0;
    carry_in = 1'b0;
    case (mode)
      alu_op_cat_8_no_ci: begin
        b[BS-1:0] = cnt[BS-1:0];
        a_lo      = cnt[BS +: W];
      end
      alu_op_cat_8_ci: begin
        b[BS-1:0] = cnt[BS-1:0];
        carry_in  = cnt[BS];
        a_lo      = cnt[BS+1 +: W];
      end
      alu_op_cat_16_no_ci: begin
        b[BS-1:0] = cnt[BS-1:0];
        a_lo      = cnt[BS +: W];
        a_hi      = cnt[BS+W +: W];
      end
      default: begin
        carry_in = cnt[0];
        a_lo     = cnt[1 +: W];
        a_hi     = cnt[W+1 +: W];
      end
    endcase
    // last vector: every bit of the active field is set
    ones = {CNT_WIDTH{1'b1}} >> (CNT_WIDTH - field_width(mode, W, BS));
    last = ((cnt & ones) == ones);
  end
endmodule

// File: rtl/alu_operand_sweeper.sv
// Sweeps every operand combination of one ALU category over a valid/ready port.
module alu_operand_sweeper
  import pkg_alu::*;
  import pkg_sweep::*;
#(
  parameter int INOUT_WIDTH  = 8,
  parameter int B_SWEEP_BITS = 8,
  parameter int CNT_WIDTH    = 2 * INOUT_WIDTH + B_SWEEP_BITS + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  alu_oper_cat            mode,
  input  logic                   vec_ready,
  output logic                   vec_valid,
  output logic [INOUT_WIDTH-1:0] a_lo,
  output logic [INOUT_WIDTH-1:0] a_hi,
  output logic [INOUT_WIDTH-1:0] b,
  output logic                   carry_in,
  output logic                   vec_last,
  output logic [CNT_WIDTH-1:0]   vec_index,
  output logic                   busy,
  output logic                   done
);
  sweep_state             state, state_n;
  logic [CNT_WIDTH-1:0]   cnt, cnt_n;
  alu_oper_cat            mode_q, mode_n;
  logic [INOUT_WIDTH-1:0] a_lo_n, a_hi_n, b_n;
  logic                   carry_n, last_n;

  // Outputs are registered from the next-state view so they line up with state.
  alu_sweep_unpack #(
    .INOUT_WIDTH (INOUT_WIDTH),
    .B_SWEEP_BITS(B_SWEEP_BITS),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_unpack (
    .cnt     (cnt_n),
    .mode    (mode_n),
    .a_lo    (a_lo_n),
    .a_hi    (a_hi_n),
    .b       (b_n),
    .carry_in(carry_n),
    .last    (last_n)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mode_n  = mode_q;
    case (state)
      SWEEP_IDLE, SWEEP_DONE: begin
        if (start) begin
          state_n = SWEEP_RUN;
          cnt_n   = '0;
          mode_n  = mode;
        end
      end
      SWEEP_RUN: begin
        // vec_valid is 1 throughout RUN, so vec_ready alone marks a handshake
        if (abort)
          state_n = SWEEP_IDLE;
        else if (vec_ready) begin
          if (vec_last) state_n = SWEEP_DONE;
          else          cnt_n   = cnt + CNT_WIDTH'(1);
        end
      end
      default: state_n = SWEEP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SWEEP_IDLE;
      cnt       <= '0;
      mode_q    <= alu_op_cat_8_no_ci;
      vec_valid <= 1'b0;
      a_lo      <= '0;
      a_hi      <= '0;
      b         <= '0;
      carry_in  <= 1'b0;
      vec_last  <= 1'b0;
      vec_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mode_q    <= mode_n;
      vec_valid <= (state_n == SWEEP_RUN);
      a_lo      <= a_lo_n;
      a_hi      <= a_hi_n;
      b         <= b_n;
      carry_in  <= carry_n;
      // last is only meaningful alongside a valid vector
      vec_last  <= last_n & (state_n == SWEEP_RUN);
      vec_index <= cnt_n;
      busy      <= (state_n == SWEEP_RUN);
      done      <= (state_n == SWEEP_DONE);
    end
  end
endmodule

// File: tb/tb_alu_operand_sweeper.sv
// Self-checking bench for alu_operand_sweeper (W=4, BS=2): table vectors plus arithmetic model.
module tb_alu_operand_sweeper;
  import pkg_alu::*;

  localparam int W  = 4;
  localparam int BS = 2;
  localparam int CW = 2 * W + BS + 1;

  logic          clk = 1'b0;
  logic          reset, start, abort, vec_ready;
  alu_oper_cat   mode_in;
  logic          vec_valid, carry_in, vec_last, busy, done;
  logic [W-1:0]  a_lo, a_hi, b;
  logic [CW-1:0] vec_index;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  alu_operand_sweeper #(
    .INOUT_WIDTH (W),
    .B_SWEEP_BITS(BS),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .mode     (mode_in),
    .vec_ready(vec_ready),
    .vec_valid(vec_valid),
    .a_lo     (a_lo),
    .a_hi     (a_hi),
    .b        (b),
    .carry_in (carry_in),
    .vec_last (vec_last),
    .vec_index(vec_index),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    alu_oper_cat  m;
    int           idx;
    logic [W-1:0] ah, al, bb;
    logic         c, l;
  } tv_t;
  tv_t tbl[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic int total_of(alu_oper_cat m);
    case (m)
      alu_op_cat_8_no_ci:  return 1 << (W + BS);
      alu_op_cat_8_ci:     return 1 << (W + 1 + BS);
      alu_op_cat_16_no_ci: return 1 << (2 * W + BS);
      default:             return 1 << (2 * W + 1);
    endcase
  endfunction

  function automatic logic [63:0] pack(logic v, logic [CW-1:0] i, logic [W-1:0] ah,
                                       logic [W-1:0] al, logic [W-1:0] bb, logic c, logic l);
    return 64'({v, i, ah, al, bb, c, l});
  endfunction

  function automatic logic [63:0] dut_vec();
    return pack(vec_valid, vec_index, a_hi, a_lo, b, carry_in, vec_last);
  endfunction

  // Expected vector from the index by place-value arithmetic.
  function automatic logic [63:0] model_vec(alu_oper_cat m, int idx);
    int nb, na, alo, ahi, bb, c;
    nb = 1 << BS; na = 1 << W;
    alo = 0; ahi = 0; bb = 0; c = 0;
    case (m)
      alu_op_cat_8_no_ci:  begin bb = idx % nb; alo = idx / nb; end
      alu_op_cat_8_ci:     begin bb = idx % nb; c = (idx / nb) % 2; alo = idx / (2 * nb); end
      alu_op_cat_16_no_ci: begin bb = idx % nb; alo = (idx / nb) % na; ahi = idx / (nb * na); end
      default:             begin c = idx % 2; alo = (idx / 2) % na; ahi = idx / (2 * na); end
    endcase
    return pack(1'b1, CW'(idx), W'(ahi), W'(alo), W'(bb), c[0], idx == total_of(m) - 1);
  endfunction

  task automatic sweep(input alu_oper_cat m, input int policy, input bit noise);
    int tot, exp_idx, nhs, cyc, stall;
    bit hs;
    tot = total_of(m); exp_idx = 0; nhs = 0; cyc = 0; stall = 0;
    mode_in = m; start = 1'b1; vec_ready = 1'b0;
    tick();
    start = 1'b0;
    mode_in = alu_oper_cat'(2'($urandom_range(0, 3)));
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_done_fall", 64'(done), 64'd0);
    while (!done && cyc < 4 * tot + 20) begin
      chk("vec", dut_vec(), model_vec(m, exp_idx));
      for (int k = 0; k < 7; k++)
        if (tbl[k].m == m && tbl[k].idx == exp_idx)
          chk($sformatf("tbl_%0d", k), 64'({a_hi, a_lo, b, carry_in, vec_last}),
              64'({tbl[k].ah, tbl[k].al, tbl[k].bb, tbl[k].c, tbl[k].l}));
      case (policy)
        0: vec_ready = 1'b1;
        1: vec_ready = 1'($urandom_range(0, 1));
        default: begin
          if (exp_idx == 7 && stall < 2) begin vec_ready = 1'b0; stall++; end
          else vec_ready = 1'b1;
        end
      endcase
      if (noise) begin
        start   = 1'($urandom_range(0, 1));
        mode_in = alu_oper_cat'(2'($urandom_range(0, 3)));
      end
      hs = vec_valid && vec_ready;
      tick();
      cyc++;
      if (hs) begin
        nhs++;
        if (exp_idx < tot - 1) exp_idx++;
      end
    end
    start = 1'b0; vec_ready = 1'b0;
    chk("count", 64'(nhs), 64'(tot));
    chk("done_state", 64'({done, busy, vec_valid}), 64'b100);
    if (policy == 0) chk("rate", 64'(cyc), 64'(tot));
    else if (policy == 2) chk("rate_stall", 64'(cyc), 64'(tot + 2));
  endtask

  initial begin
    int guard;
    tbl[0] = '{alu_op_cat_8_no_ci,    5, 4'd0,  4'd1,  4'd1, 1'b0, 1'b0};
    tbl[1] = '{alu_op_cat_8_no_ci,   62, 4'd0,  4'd15, 4'd2, 1'b0, 1'b0};
    tbl[2] = '{alu_op_cat_8_no_ci,   63, 4'd0,  4'd15, 4'd3, 1'b0, 1'b1};
    tbl[3] = '{alu_op_cat_16_ci,      3, 4'd0,  4'd1,  4'd0, 1'b1, 1'b0};
    tbl[4] = '{alu_op_cat_16_ci,    511, 4'd15, 4'd15, 4'd0, 1'b1, 1'b1};
    tbl[5] = '{alu_op_cat_8_ci,       7, 4'd0,  4'd0,  4'd3, 1'b1, 1'b0};
    tbl[6] = '{alu_op_cat_16_no_ci, 1023, 4'd15, 4'd15, 4'd3, 1'b0, 1'b1};

    reset = 1'b0; start = 1'b0; abort = 1'b0; vec_ready = 1'b0; mode_in = alu_op_cat_16_ci;
    tick(); tick();
    chk("reset_vec", dut_vec(), 64'd0);
    chk("reset_flags", 64'({busy, done}), 64'd0);
    reset = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_ignored", 64'({busy, done, vec_valid}), 64'd0);

    sweep(alu_op_cat_8_no_ci, 0, 1'b0);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("done_hold", 64'({done, busy, vec_valid}), 64'b100);

    sweep(alu_op_cat_16_ci, 0, 1'b0);
    sweep(alu_op_cat_8_ci, 2, 1'b0);
    sweep(alu_op_cat_16_no_ci, 1, 1'b1);

    // abort coinciding with a handshake at index 10
    mode_in = alu_op_cat_8_no_ci; start = 1'b1; vec_ready = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (vec_index != CW'(10) && guard < 50) begin tick(); guard++; end
    chk("abort_reach", 64'(vec_index), 64'd10);
    abort = 1'b1; vec_ready = 1'b1;
    tick();
    abort = 1'b0; vec_ready = 1'b0;
    chk("abort_vec", dut_vec(), pack(1'b0, CW'(10), 4'd0, 4'd2, 4'd2, 1'b0, 1'b0));
    chk("abort_flags", 64'({busy, done}), 64'd0);
    sweep(alu_op_cat_16_no_ci, 0, 1'b1);

    // reset mid-sweep with start/abort/mode all active
    mode_in = alu_op_cat_8_ci; start = 1'b1; vec_ready = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (vec_index != CW'(20) && guard < 50) begin tick(); guard++; end
    chk("rst_reach", 64'(vec_index), 64'd20);
    reset = 1'b0; start = 1'b1; abort = 1'b1; mode_in = alu_op_cat_16_ci;
    tick();
    chk("rst_mid_vec", dut_vec(), 64'd0);
    chk("rst_mid_flags", 64'({busy, done}), 64'd0);
    tick();
    chk("rst_hold_vec", dut_vec(), 64'd0);
    reset = 1'b1; start = 1'b0; abort = 1'b0; vec_ready = 1'b0;
    tick();
    chk("rst_release", 64'({dut_vec(), busy, done}), 64'd0);
    sweep(alu_op_cat_8_no_ci, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
